// File: rtl/requant_pkg.sv
// Shared constants and helpers for the requantisation pipeline:
// output saturation bounds, shift-amount clamp and the saturation counter width.
package requant_pkg;

  localparam int unsigned SAT_CNT_W = 32;

  function automatic longint sat_max(input int unsigned out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

  // Limit a requested shift to what the input width can meaningfully use.
  function automatic int clamp_shift(input int sh, input int unsigned in_w);
    int lim;
    lim = int'(in_w) - 1;
    if (sh > lim) return lim;
    if (sh < -lim) return -lim;
    return sh;
  endfunction

endpackage

// File: rtl/requant_pipeline_if.sv
// Stream bus for the requantisation pipeline: input beats, output beats
// and saturation statistics.
interface requant_pipeline_if #(
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned LANES       = 16,
  parameter int unsigned SHIFT_WIDTH = 8
);
  logic signed [SHIFT_WIDTH-1:0]     ShiftAmount;
  logic                              InValid;
  logic                              InReady;
  logic [LANES-1:0][IN_WIDTH-1:0]    InData;
  logic                              OutValid;
  logic                              OutReady;
  logic [LANES-1:0][OUT_WIDTH-1:0]   OutData;
  logic [LANES-1:0]                  OutSatMask;
  logic                              ClearStats;
  logic [requant_pkg::SAT_CNT_W-1:0] SatCount;

  modport master (
    output ShiftAmount, InValid, InData, OutReady, ClearStats,
    input  InReady, OutValid, OutData, OutSatMask, SatCount
  );

  modport slave (
    input  ShiftAmount, InValid, InData, OutReady, ClearStats,
    output InReady, OutValid, OutData, OutSatMask, SatCount
  );
endinterface

// File: rtl/requant_lane.sv
// One lane: S1 shifts (and optionally rounds) in double width, S2 saturates.
// Rounding of right shifts is enabled by defining REQUANT_ROUNDING_EN.
module requant_lane
  import requant_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SH_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s1_en,
  input  logic                   s2_en,
  input  logic signed [SH_W-1:0] shift,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   sat
);
  localparam int unsigned W2 = 2 * IN_WIDTH;
  localparam logic signed [W2-1:0] HI = W2'(sat_max(OUT_WIDTH));
  localparam logic signed [W2-1:0] LO = W2'(sat_min(OUT_WIDTH));

  logic signed [W2-1:0]  ext_c;
  logic signed [W2-1:0]  shifted_c;
  logic [SH_W-1:0]       mag_c;
  logic signed [W2-1:0]  acc;
  logic [OUT_WIDTH-1:0]  res_c;
  logic                  sat_c;

  // Double width keeps every left shift of a clamped amount from wrapping.
  always_comb begin
    ext_c     = {{IN_WIDTH{in_data[IN_WIDTH-1]}}, in_data};
    mag_c     = shift[SH_W-1] ? SH_W'(-shift) : SH_W'(shift);
    shifted_c = ext_c;
    if (!shift[SH_W-1]) begin
      shifted_c = ext_c <<< mag_c;
    end else begin
`ifdef REQUANT_ROUNDING_EN
      shifted_c = (ext_c + (W2'(1) <<< (mag_c - SH_W'(1)))) >>> mag_c;
`else
      shifted_c = ext_c >>> mag_c;
`endif
    end
  end

  always_comb begin
    res_c = acc[OUT_WIDTH-1:0];
    sat_c = 1'b0;
    if (acc > HI) begin
      res_c = HI[OUT_WIDTH-1:0];
      sat_c = 1'b1;
    end else if (acc < LO) begin
      res_c = LO[OUT_WIDTH-1:0];
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      out_data <= '0;
      sat      <= 1'b0;
    end else begin
      if (s1_en) acc <= shifted_c;
      if (s2_en) begin
        out_data <= res_c;
        sat      <= sat_c;
      end
    end
  end
endmodule

// File: rtl/requant_pipeline.sv
// Two-stage multi-lane requantiser (shift/round, then saturate) with
// valid/ready flow control and a saturating clamp counter.
// Rounding of right shifts is enabled by defining REQUANT_ROUNDING_EN.
module requant_pipeline
  import requant_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned LANES       = 16,
  parameter int unsigned SHIFT_WIDTH = 8
) (
  input logic          Clk,
  input logic          Rst,
  requant_pipeline_if.slave bus
);
  localparam int unsigned SH_W  = $clog2(IN_WIDTH) + 1;
  localparam int unsigned POP_W = $clog2(LANES + 1);

  logic signed [SHIFT_WIDTH-1:0]   shift_in;
  logic signed [SH_W-1:0]          shift_c;
  logic                            s1_valid;
  logic                            s2_valid;
  logic                            s1_load_c;
  logic                            s2_load_c;
  logic [LANES-1:0][OUT_WIDTH-1:0] lane_out;
  logic [LANES-1:0]                lane_sat;
  logic [POP_W-1:0]                pop_c;
  logic [SAT_CNT_W:0]              sum_c;
  logic [SAT_CNT_W-1:0]            sat_count;

  assign shift_in = bus.ShiftAmount;
  assign shift_c  = SH_W'(clamp_shift(int'(shift_in), IN_WIDTH));

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    s2_load_c = !s2_valid || bus.OutReady;
    s1_load_c = !s1_valid || s2_load_c;
  end

  assign bus.InReady    = s1_load_c;
  assign bus.OutValid   = s2_valid;
  assign bus.OutData    = lane_out;
  assign bus.OutSatMask = lane_sat;
  assign bus.SatCount   = sat_count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load_c) s1_valid <= bus.InValid;
      if (s2_load_c) s2_valid <= s1_valid;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SH_W      (SH_W)
    ) u_lane (
      .clk      (Clk),
      .rst      (Rst),
      .s1_en    (s1_load_c && bus.InValid),
      .s2_en    (s2_load_c && s1_valid),
      .shift    (shift_c),
      .in_data  (bus.InData[i]),
      .out_data (lane_out[i]),
      .sat      (lane_sat[i])
    );
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(LANES); i++) pop_c = pop_c + POP_W'(lane_sat[i]);
    sum_c = {1'b0, sat_count} + (SAT_CNT_W + 1)'(pop_c);
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sat_count <= '0;
    end else if (bus.ClearStats) begin
      sat_count <= '0;
    end else if (s2_valid && bus.OutReady) begin
      sat_count <= sum_c[SAT_CNT_W] ? '1 : sum_c[SAT_CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_requant_pipeline.sv
// Scoreboard bench for requant_pipeline; expectations follow REQUANT_ROUNDING_EN.
module tb_requant_pipeline;
  localparam int unsigned LANES = 16;
  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 8;
`ifdef REQUANT_ROUNDING_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef logic [LANES-1:0][IN_W-1:0] in_t;
  typedef struct packed {
    logic [LANES-1:0][OUT_W-1:0] data;
    logic [LANES-1:0]            mask;
  } beat_t;

  logic   clk = 1'b0;
  logic   rst;
  int     errors = 0;
  int     checks = 0;
  beat_t  q[$];
  longint exp_cnt = 0;

  requant_pipeline_if bus ();

  requant_pipeline dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic beat_t model(input in_t d, input int sh);
    beat_t  r;
    int     s;
    longint v;
    s = sh;
    if (s > 31) s = 31;
    if (s < -31) s = -31;
    for (int i = 0; i < int'(LANES); i++) begin
      v = longint'($signed(d[i]));
      if (s >= 0) begin
        v = v <<< s;
      end else begin
        if (RND) v = v + (longint'(1) <<< (-s - 1));
        v = v >>> (-s);
      end
      r.mask[i] = 1'b0;
      if (v > 127) begin
        v = 127;
        r.mask[i] = 1'b1;
      end else if (v < -128) begin
        v = -128;
        r.mask[i] = 1'b1;
      end
      r.data[i] = 8'(v);
    end
    return r;
  endfunction

  function automatic in_t rand_beat(input int range);
    in_t d;
    for (int i = 0; i < int'(LANES); i++)
      d[i] = 32'(int'($urandom_range(0, 2 * range)) - range);
    return d;
  endfunction

  // One cycle: drive, check outputs against the scoreboard, track handshakes.
  task automatic step(input logic iv, input in_t d, input int sh, input logic ordy,
                      input logic clr, output logic acc);
    logic hs;
    @(negedge clk);
    bus.InValid     = iv;
    bus.InData      = d;
    bus.ShiftAmount = 8'(sh);
    bus.OutReady    = ordy;
    bus.ClearStats  = clr;
    #1;
    check("sat_count", 128'(bus.SatCount), 128'(exp_cnt));
    if (q.size() == 0) begin
      check("idle_valid", 128'(bus.OutValid), 128'(0));
    end else if (bus.OutValid) begin
      check("out_data", 128'(bus.OutData), 128'(q[0].data));
      check("out_mask", 128'(bus.OutSatMask), 128'(q[0].mask));
    end
    hs = bus.OutValid && ordy && (q.size() > 0);
    if (clr) exp_cnt = 0;
    else if (hs) begin
      exp_cnt = exp_cnt + longint'($countones(q[0].mask));
      if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
    end
    if (hs) void'(q.pop_front());
    acc = iv && bus.InReady;
    if (acc) q.push_back(model(d, sh));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.InValid    = 1'b0;
    bus.OutReady   = 1'b1;
    bus.ClearStats = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    #1;
    check("rst_valid", 128'(bus.OutValid), 128'(0));
    check("rst_data", 128'(bus.OutData), 128'(0));
    check("rst_mask", 128'(bus.OutSatMask), 128'(0));
    check("rst_count", 128'(bus.SatCount), 128'(0));
    check("rst_inready", 128'(bus.InReady), 128'(1));
  endtask

  // Single beat through an idle pipe: checks latency and one lane's value.
  task automatic directed(input in_t d, input int sh, input int lane,
                          input logic [7:0] ev, input logic em, input string tag);
    logic a;
    step(1'b1, d, sh, 1'b1, 1'b0, a);
    check({tag, "_acc"}, 128'(a), 128'(1));
    step(1'b0, '0, 0, 1'b1, 1'b0, a);
    check({tag, "_lat1"}, 128'(bus.OutValid), 128'(0));
    step(1'b0, '0, 0, 1'b1, 1'b0, a);
    check({tag, "_lat2"}, 128'(bus.OutValid), 128'(1));
    check({tag, "_val"}, 128'(bus.OutData[lane]), 128'(ev));
    check({tag, "_msk"}, 128'(bus.OutSatMask[lane]), 128'(em));
  endtask

  initial begin
    in_t  d;
    logic a;
    int   sent;
    rst             = 1'b1;
    bus.InValid     = 1'b0;
    bus.InData      = '0;
    bus.ShiftAmount = '0;
    bus.OutReady    = 1'b0;
    bus.ClearStats  = 1'b0;
    do_reset();

    d = rand_beat(2000); d[0] = 32'd1000; d[1] = 32'd1004;
    directed(d, -3, 0, 8'd125, 1'b0, "r1000");
    check("r1004_val", 128'(bus.OutData[1]), 128'(RND ? 8'd126 : 8'd125));
    d = rand_beat(2000); d[0] = 32'd100;
    directed(d, 1, 0, 8'd127, 1'b1, "l100");
    d = rand_beat(2000); d[0] = 32'h4000_0000;
    directed(d, 4, 0, 8'd127, 1'b1, "nowrap");
    d = rand_beat(2000); d[0] = 32'(-300);
    directed(d, 0, 0, 8'h80, 1'b1, "neg300");
    d = rand_beat(2000); d[0] = 32'hFFFF_FFFF;
    directed(d, -40, 0, RND ? 8'h00 : 8'hFF, 1'b0, "clamp40");

    // Eight beats back to back with the sink stalled on cycles 3..5.
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
      step(sent < 8, rand_beat(3000), int'($urandom_range(0, 12)) - 8,
           !(c >= 3 && c <= 5), 1'b0, a);
      if (c == 4) check("inready_stall", 128'(bus.InReady), 128'(0));
      if (a) sent++;
    end
    check("stream_sent", 128'(sent), 128'(8));
    check("stream_drain", 128'(q.size()), 128'(0));

    // Four beats with exactly three clamped lanes each.
    step(1'b0, '0, 0, 1'b1, 1'b1, a);
    sent = 0;
    for (int c = 0; c < 30 && (sent < 4 || q.size() > 0); c++) begin
      d = rand_beat(100); d[0] = 32'd1000; d[1] = 32'(-1000); d[2] = 32'd500;
      step(sent < 4, d, 0, 1'b1, 1'b0, a);
      if (a) sent++;
    end
    step(1'b0, '0, 0, 1'b1, 1'b0, a);
    check("sat12", 128'(bus.SatCount), 128'(12));

    // Clear lands on the same edge as a saturating handshake.
    d = rand_beat(100); d[0] = 32'd1000; d[1] = 32'(-1000); d[2] = 32'd500;
    step(1'b1, d, 0, 1'b0, 1'b0, a);
    for (int c = 0; c < 5 && !bus.OutValid; c++) step(1'b0, '0, 0, 1'b0, 1'b0, a);
    check("clr_ready", 128'(bus.OutValid), 128'(1));
    step(1'b0, '0, 0, 1'b1, 1'b1, a);
    step(1'b0, '0, 0, 1'b1, 1'b0, a);
    check("sat_clr", 128'(bus.SatCount), 128'(0));

    // Random traffic with random back-pressure and shifts, then drain.
    for (int c = 0; c < 60; c++)
      step(1'($urandom_range(0, 1)), rand_beat(1 << 20), int'($urandom_range(0, 80)) - 40,
           1'($urandom_range(0, 1)), 1'b0, a);
    for (int c = 0; c < 20 && q.size() > 0; c++) step(1'b0, '0, 0, 1'b1, 1'b0, a);
    check("rand_drain", 128'(q.size()), 128'(0));

    // Reset with beats in flight: nothing may emerge afterwards.
    step(1'b1, rand_beat(500), -2, 1'b0, 1'b0, a);
    step(1'b1, rand_beat(500), -2, 1'b0, 1'b0, a);
    do_reset();
    repeat (4) step(1'b0, '0, 0, 1'b1, 1'b0, a);
    check("final_drain", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/requant_pipeline.md
REQUANT_PIPELINE -- requirements
Module: requant_pipeline

Interface
REQ-001 Parameter IN_WIDTH, default 32, signed accumulator width per lane.
REQ-002 Parameter OUT_WIDTH, default 8, signed output width per lane.
REQ-003 Parameter LANES, default 16, lanes processed per beat.
REQ-004 Parameter SHIFT_WIDTH, default 8, signed shift-amount width.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Rst  input  1  synchronous, active-high reset.
REQ-007 ShiftAmount  input  SHIFT_WIDTH signed  per-beat shift; positive = left, negative = arithmetic right; sampled with InData.
REQ-008 InValid / InReady  input / output  1 each  upstream valid/ready handshake.
REQ-009 InData  input  [LANES][IN_WIDTH] signed  accumulator values.
REQ-010 OutValid / OutReady  output / input  1 each  downstream valid/ready handshake.
REQ-011 OutData  output  [LANES][OUT_WIDTH] signed  requantised values.
REQ-012 OutSatMask  output  LANES  bit i set when lane i was clamped on this beat.
REQ-013 ClearStats  input  1  synchronous clear of SatCount.
REQ-014 SatCount  output  32  running count of saturated lanes.

Function
REQ-015 The block SHALL be a two-stage pipeline, S1 (shift/round) then S2 (saturate); latency from input handshake to OutValid is exactly 2 cycles when never stalled.
REQ-016 The block SHALL accept a beat on cycles where InValid && InReady, and deliver a beat on cycles where OutValid && OutReady.
REQ-017 S2 SHALL load when S2 is empty or OutReady=1; S1 SHALL load when S1 is empty or S2 loads; InReady = !S1valid || S2-load (full throughput, one beat per cycle, no bubbles).
REQ-018 While OutValid=1 && OutReady=0, OutData, OutSatMask and OutValid SHALL hold stable.
REQ-019 ShiftAmount SHALL be clamped to [-(IN_WIDTH-1), +(IN_WIDTH-1)] before use.
REQ-020 S1 SHALL compute in 2*IN_WIDTH signed width so a left shift never wraps; overflowing values reach S2 intact.
REQ-021 For right shifts of n>0, S1 SHALL add 2^(n-1) before the arithmetic shift (round half toward +infinity) when rounding is enabled (REQ-030).
REQ-022 S2 SHALL clamp to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1], set the lane's OutSatMask bit iff clamped, else output the low OUT_WIDTH bits.
REQ-023 On each output handshake SatCount SHALL increase by popcount(OutSatMask), saturating at 2^32-1.
REQ-024 ClearStats=1 SHALL zero SatCount next edge; it takes priority over a simultaneous increment, whose contribution is discarded.
REQ-025 Shift amount zero SHALL pass values unshifted, with saturation applied.

Reset
REQ-026 On Rst=1: S1/S2 valid flags, OutValid and SatCount SHALL be 0 after the edge; OutData and OutSatMask SHALL be 0.
REQ-027 InReady SHALL be 1 on the first cycle after reset deasserts.
REQ-028 Rst mid-operation SHALL discard all in-flight beats; no partial beat is delivered afterwards.

Configuration
REQ-029 Macro REQUANT_ROUNDING_EN SHALL control rounding.
REQ-030 Defined: right shifts round per REQ-021. Undefined: pure truncating arithmetic right shift (floor); all other behaviour identical.

Structure
REQ-031 Package requant_pkg SHALL hold the saturation-bound functions of OUT_WIDTH, the shift-clamp function and the SatCount width constant.
REQ-032 Per-lane shift/round/saturate datapath SHALL be sub-module requant_lane, instantiated LANES times; handshake and SatCount logic stay in requant_pipeline.

Verification
REQ-033 Lane in 1000, shift -3, rounding on -> out 125 (1000/8), mask 0; in 1004, shift -3 -> 126 on, 125 off.
REQ-034 In 100, shift +1 -> 127, mask 1; in 0x40000000, shift +4 -> 127 (no wrap); in -300, shift 0 -> -128, mask 1.
REQ-035 Shift -40 (IN_WIDTH 32) -> clamped to -31; in -1 -> -1 off, 0 on.
REQ-036 Stream 8 beats with OutReady 0 for cycles 3-5 -> no drop/duplicate, order preserved, outputs stable while stalled, InReady low once both stages full.
REQ-037 4 beats each with 3 saturated lanes -> SatCount 12; ClearStats on final handshake -> SatCount 0; Rst mid-stream -> OutValid 0 next cycle, no stale beat.
